// File: rtl/serial_pkg.sv
// Shared definitions for the 7E1 serial receiver and transmitter.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: FSM state codes (also driven out on db_estado for debug),
// default bit timing for 115200 baud at 50 MHz, and an even-parity helper.
package serial_pkg;

  localparam int CICLOS_BIT_PADRAO  = 434;  // clock cycles per bit
  localparam int CICLOS_MEIO_PADRAO = 217;  // falling edge of start bit to mid-bit

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    INICIO   = 4'd1,
    RECEPCAO = 4'd2,
    PARADA   = 4'd3,
    ARMAZENA = 4'd4,
    FINAL    = 4'd5
  } estado_t;

  // 1 when the vector holds an odd number of ones, i.e. fails even parity.
  function automatic logic erro_paridade_par(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rx_serial_7e1_if.sv
// Bundle of the 7E1 receiver's line input, consumer handshake and status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; limpa is the consumer's acknowledge of tem_dado.
//
// Ports (slave = receiver side):
//   dados_serial  in   asynchronous RX line, idle high
//   limpa         in   consumer acknowledge, clears tem_dado / sobreposicao
//   dado_recebido out  last stored 7-bit character
//   tem_dado      out  stored character not yet acknowledged
//   pronto        out  one-cycle pulse at the end of every complete frame
//   erro_paridade out  last complete frame failed even parity
//   erro_quadro   out  last complete frame had a stop bit of 0
//   sobreposicao  out  a character was stored while tem_dado was already 1
//   db_estado     out  current FSM state code
interface rx_serial_7e1_if;
  logic       dados_serial;
  logic       limpa;
  logic [6:0] dado_recebido;
  logic       tem_dado;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_quadro;
  logic       sobreposicao;
  logic [3:0] db_estado;

  modport master (
    output dados_serial, limpa,
    input  dado_recebido, tem_dado, pronto, erro_paridade,
           erro_quadro, sobreposicao, db_estado
  );

  modport slave (
    input  dados_serial, limpa,
    output dado_recebido, tem_dado, pronto, erro_paridade,
           erro_quadro, sobreposicao, db_estado
  );
endinterface

// File: rtl/contador_m.sv
// Modulo-M cycle counter with synchronous clear and count enable.
// Latency: o_q updates one cycle after i_conta / i_zera.
// Backpressure: none; counting simply pauses while i_conta is low.
//
// Ports: i_clock, i_zera (sync clear, wins over count), i_conta (enable),
//        o_q (current count), o_fim (high while o_q == M-1, i.e. on the wrap cycle).
module contador_m #(
  parameter int M = 434,
  parameter int N = $clog2(M)
) (
  input  logic         i_clock,
  input  logic         i_zera,
  input  logic         i_conta,
  output logic [N-1:0] o_q,
  output logic         o_fim
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clock) begin
    if (i_zera) begin
      r_q <= '0;
    end else if (i_conta) begin
      if (r_q == N'(M - 1)) begin
        r_q <= '0;
      end else begin
        r_q <= r_q + N'(1);
      end
    end
  end

  assign o_q   = r_q;
  assign o_fim = (r_q == N'(M - 1));

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start, 7 data bits LSB first, even parity, 1 stop.
// Latency: pronto rises 2 cycles after the stop-bit sample; status/data update 1 cycle before pronto.
// Backpressure: none; a store while tem_dado is still set overwrites and flags sobreposicao.
//
// Ports: clock, reset (sync, active high), bus (rx_serial_7e1_if.slave, see interface).
module rx_serial_7e1
  import serial_pkg::*;
#(
  parameter int CICLOS_BIT  = CICLOS_BIT_PADRAO,
  parameter int CICLOS_MEIO = CICLOS_MEIO_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  rx_serial_7e1_if.slave    bus
);

  localparam int CW = $clog2(CICLOS_BIT);

  // Synchroniser plus one extra stage for falling-edge detection.
  logic r_sinc1, r_sinc2, r_rx_ant;

  estado_t    r_estado;
  logic [7:0] r_desloc;     // d0..d6 then parity; newest bit enters at the MSB
  logic [2:0] r_nbits;      // bits already shifted in during recepcao
  logic       r_parada;     // sampled stop bit
  logic [6:0] r_dado;
  logic       r_tem_dado;
  logic       r_pronto;
  logic       r_erro_par;
  logic       r_erro_quad;
  logic       r_sobrepos;

  logic [CW-1:0] w_q;
  logic          w_fim;
  logic          w_meio;
  logic          w_zera;
  logic          w_conta;
  logic          w_borda;
  logic          w_erro_par;
  logic          w_guarda;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sinc1  <= 1'b1;
      r_sinc2  <= 1'b1;
      r_rx_ant <= 1'b1;
    end else begin
      r_sinc1  <= bus.dados_serial;
      r_sinc2  <= r_sinc1;
      r_rx_ant <= r_sinc2;
    end
  end

  assign w_borda = r_rx_ant & ~r_sinc2;
  assign w_meio  = (w_q == CW'(CICLOS_MEIO - 1));

  // The counter sits at zero while idle and is re-zeroed at the mid-start
  // decision, so every later sample lands a whole bit period further on.
  assign w_zera  = reset || (r_estado == INICIAL) || (r_estado == INICIO && w_meio);
  assign w_conta = (r_estado == INICIO) || (r_estado == RECEPCAO) || (r_estado == PARADA);

  contador_m #(
    .M (CICLOS_BIT),
    .N (CW)
  ) u_contador (
    .i_clock (clock),
    .i_zera  (w_zera),
    .i_conta (w_conta),
    .o_q     (w_q),
    .o_fim   (w_fim)
  );

  assign w_erro_par = erro_paridade_par(r_desloc);
  assign w_guarda   = !w_erro_par && r_parada;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= INICIAL;
      r_desloc    <= '0;
      r_nbits     <= '0;
      r_parada    <= 1'b0;
      r_dado      <= '0;
      r_tem_dado  <= 1'b0;
      r_pronto    <= 1'b0;
      r_erro_par  <= 1'b0;
      r_erro_quad <= 1'b0;
      r_sobrepos  <= 1'b0;
    end else begin
      r_pronto <= 1'b0;

      // Acknowledge first; a store later in this block overrides it.
      if (bus.limpa) begin
        r_tem_dado <= 1'b0;
        r_sobrepos <= 1'b0;
      end

      case (r_estado)
        INICIAL: begin
          if (w_borda) begin
            r_estado <= INICIO;
          end
        end

        INICIO: begin
          if (w_meio) begin
            // Line back high at mid start bit: treat as a glitch.
            if (!r_sinc2) begin
              r_estado <= RECEPCAO;
              r_nbits  <= '0;
            end else begin
              r_estado <= INICIAL;
            end
          end
        end

        RECEPCAO: begin
          if (w_fim) begin
            r_desloc <= {r_sinc2, r_desloc[7:1]};
            r_nbits  <= r_nbits + 3'd1;
            if (r_nbits == 3'd7) begin
              r_estado <= PARADA;
            end
          end
        end

        PARADA: begin
          if (w_fim) begin
            r_parada <= r_sinc2;
            r_estado <= ARMAZENA;
          end
        end

        ARMAZENA: begin
          r_erro_par  <= w_erro_par;
          r_erro_quad <= ~r_parada;
          if (w_guarda) begin
            r_dado     <= r_desloc[6:0];
            r_tem_dado <= 1'b1;
            if (r_tem_dado) begin
              r_sobrepos <= 1'b1;
            end
          end
          r_estado <= FINAL;
        end

        FINAL: begin
          r_pronto <= 1'b1;
          r_estado <= INICIAL;
        end

        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  assign bus.dado_recebido = r_dado;
  assign bus.tem_dado      = r_tem_dado;
  assign bus.pronto        = r_pronto;
  assign bus.erro_paridade = r_erro_par;
  assign bus.erro_quadro   = r_erro_quad;
  assign bus.sobreposicao  = r_sobrepos;
  assign bus.db_estado     = r_estado;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Bench for rx_serial_7e1: directed frames, a frame-level reference model and per-cycle compare.
// Latency: model places the store one cycle after the stop sample and pronto one cycle later.
// Backpressure: n/a.
module tb_rx_serial_7e1;

  localparam int BIT  = 434;
  localparam int MEIO = 217;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rx_serial_7e1_if bus();

  rx_serial_7e1 #(
    .CICLOS_BIT  (BIT),
    .CICLOS_MEIO (MEIO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Edge index and the control inputs the DUT saw at that edge.
  int   cyc     = 0;
  logic rst_e   = 1'b1;
  logic limpa_e = 1'b0;

  always @(posedge clock) begin
    cyc     = cyc + 1;
    rst_e   = reset;
    limpa_e = bus.limpa;
  end

  // Frame-level model: expected outputs plus one pending frame outcome.
  logic [6:0] exp_dado  = '0;
  logic       exp_tem   = 1'b0;
  logic       exp_ep    = 1'b0;
  logic       exp_eq    = 1'b0;
  logic       exp_sob   = 1'b0;
  logic       exp_pronto = 1'b0;
  int         pend_cyc  = -1;
  int         pron_cyc  = -1;
  logic [6:0] pend_data = '0;
  logic       pend_par  = 1'b0;
  logic       pend_stop = 1'b1;
  int         pronto_cnt = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (edge %0d)", nome, act, expv, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic tem_antes;
    if (rst_e) begin
      exp_dado = '0; exp_tem = 1'b0; exp_ep = 1'b0;
      exp_eq = 1'b0; exp_sob = 1'b0;
      pend_cyc = -1; pron_cyc = -1;
    end else begin
      tem_antes = exp_tem;
      if (limpa_e) begin
        exp_tem = 1'b0;
        exp_sob = 1'b0;
      end
      if (cyc == pend_cyc) begin
        exp_ep = ^{pend_par, pend_data};
        exp_eq = !pend_stop;
        if (!exp_ep && !exp_eq) begin
          exp_dado = pend_data;
          exp_tem  = 1'b1;
          if (tem_antes) exp_sob = 1'b1;
        end
        pron_cyc = cyc + 1;
        pend_cyc = -1;
      end
    end
    exp_pronto = (cyc == pron_cyc);
    chk("pronto",        32'(bus.pronto),        32'(exp_pronto));
    chk("dado_recebido", 32'(bus.dado_recebido), 32'(exp_dado));
    chk("tem_dado",      32'(bus.tem_dado),      32'(exp_tem));
    chk("erro_paridade", 32'(bus.erro_paridade), 32'(exp_ep));
    chk("erro_quadro",   32'(bus.erro_quadro),   32'(exp_eq));
    chk("sobreposicao",  32'(bus.sobreposicao),  32'(exp_sob));
    if (bus.pronto === 1'b1) pronto_cnt++;
  end

  task automatic espera(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends one frame; aborta_bit >= 0 pulses reset in the middle of that data bit.
  task automatic envia(input logic [6:0] d, input logic p, input logic s, input int aborta_bit);
    logic [9:0] q;
    int t0;
    q = {s, p, d, 1'b0};
    @(posedge clock);
    #1;
    t0 = cyc;
    pend_data = d;
    pend_par  = p;
    pend_stop = s;
    // edge detect at t0+3, mid start at +MEIO, 8 data/parity + stop samples, store one edge later
    pend_cyc  = t0 + 4 + MEIO + 9 * BIT;
    for (int k = 0; k < 10; k++) begin
      bus.dados_serial = q[k];
      if (aborta_bit >= 0 && k == aborta_bit + 1) begin
        espera(200);
        bus.dados_serial = 1'b1;
        reset = 1'b1;
        espera(4);
        reset = 1'b0;
        return;
      end
      espera(BIT);
    end
    bus.dados_serial = 1'b1;
  endtask

  task automatic pulso_limpa();
    bus.limpa = 1'b1;
    espera(1);
    bus.limpa = 1'b0;
  endtask

  initial begin
    int p0;
    bus.dados_serial = 1'b1;
    bus.limpa        = 1'b0;
    reset            = 1'b1;
    espera(3);
    chk("rst_dado",  32'(bus.dado_recebido), 32'h0);
    chk("rst_tem",   32'(bus.tem_dado),      32'h0);
    chk("rst_pronto",32'(bus.pronto),        32'h0);
    chk("rst_ep",    32'(bus.erro_paridade), 32'h0);
    chk("rst_eq",    32'(bus.erro_quadro),   32'h0);
    chk("rst_sob",   32'(bus.sobreposicao),  32'h0);
    chk("rst_estado",32'(bus.db_estado),     32'h0);
    reset = 1'b0;
    espera(10);

    // 'A', good parity and stop
    p0 = pronto_cnt;
    envia(7'h41, 1'b0, 1'b1, -1);
    espera(20);
    chk("A_dado",   32'(bus.dado_recebido), 32'h41);
    chk("A_tem",    32'(bus.tem_dado),      32'h1);
    chk("A_ep",     32'(bus.erro_paridade), 32'h0);
    chk("A_eq",     32'(bus.erro_quadro),   32'h0);
    chk("A_pronto", 32'(pronto_cnt - p0),   32'd1);
    chk("A_estado", 32'(bus.db_estado),     32'h0);
    pulso_limpa();
    espera(2);
    chk("limpa1_tem", 32'(bus.tem_dado), 32'h0);

    // 'A' with wrong parity: flag only, no store
    p0 = pronto_cnt;
    envia(7'h41, 1'b1, 1'b1, -1);
    espera(20);
    chk("par_ep",     32'(bus.erro_paridade), 32'h1);
    chk("par_eq",     32'(bus.erro_quadro),   32'h0);
    chk("par_dado",   32'(bus.dado_recebido), 32'h41);
    chk("par_tem",    32'(bus.tem_dado),      32'h0);
    chk("par_pronto", 32'(pronto_cnt - p0),   32'd1);

    // 100-cycle low glitch, shorter than the mid-start wait
    p0 = pronto_cnt;
    bus.dados_serial = 1'b0;
    espera(50);
    chk("glitch_inicio", 32'(bus.db_estado), 32'h1);
    espera(50);
    bus.dados_serial = 1'b1;
    espera(130);
    chk("glitch_inicial", 32'(bus.db_estado),     32'h0);
    chk("glitch_pronto",  32'(pronto_cnt - p0),   32'd0);
    chk("glitch_ep",      32'(bus.erro_paridade), 32'h1);
    espera(20);

    // 7'h35 with stop bit 0: framing error, no store
    p0 = pronto_cnt;
    envia(7'h35, 1'b0, 1'b0, -1);
    espera(20);
    chk("quad_eq",     32'(bus.erro_quadro),   32'h1);
    chk("quad_ep",     32'(bus.erro_paridade), 32'h0);
    chk("quad_dado",   32'(bus.dado_recebido), 32'h41);
    chk("quad_tem",    32'(bus.tem_dado),      32'h0);
    chk("quad_pronto", 32'(pronto_cnt - p0),   32'd1);

    // '1' then '2' without acknowledge: overrun
    p0 = pronto_cnt;
    envia(7'h31, 1'b1, 1'b1, -1);
    espera(20);
    chk("ov1_sob", 32'(bus.sobreposicao), 32'h0);
    envia(7'h32, 1'b1, 1'b1, -1);
    espera(20);
    chk("ov_dado",   32'(bus.dado_recebido), 32'h32);
    chk("ov_tem",    32'(bus.tem_dado),      32'h1);
    chk("ov_sob",    32'(bus.sobreposicao),  32'h1);
    chk("ov_eq",     32'(bus.erro_quadro),   32'h0);
    chk("ov_pronto", 32'(pronto_cnt - p0),   32'd2);
    pulso_limpa();
    espera(2);
    chk("ov_limpa_tem", 32'(bus.tem_dado),     32'h0);
    chk("ov_limpa_sob", 32'(bus.sobreposicao), 32'h0);

    // reset during data bit 3, then a clean '#'
    p0 = pronto_cnt;
    envia(7'h23, 1'b1, 1'b1, 3);
    espera(20);
    chk("ab_pronto", 32'(pronto_cnt - p0),   32'd0);
    chk("ab_dado",   32'(bus.dado_recebido), 32'h0);
    chk("ab_estado", 32'(bus.db_estado),     32'h0);
    envia(7'h23, 1'b1, 1'b1, -1);
    espera(20);
    chk("rs_dado",   32'(bus.dado_recebido), 32'h23);
    chk("rs_tem",    32'(bus.tem_dado),      32'h1);
    chk("rs_pronto", 32'(pronto_cnt - p0),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
